// File: rtl/encrypt_stream.sv
// Streaming LWE encryption: sums the masked public-key columns of each row,
// LANES entries per beat, and emits one ciphertext element per row (b row carries m*DELTA).
module encrypt_stream #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 21,
  parameter int DIMENSION          = 1,
  parameter int BIG_N              = 30,
  parameter int LANES              = 1,
  localparam int ROW_W = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [PLAINTEXT_WIDTH-1:0]            plaintext,
  input  logic [BIG_N-1:0]                      noise_select,
  output logic                                  busy,
  input  logic                                  pk_valid,
  output logic                                  pk_ready,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]     pk_data,
  output logic                                  ct_valid,
  input  logic                                  ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]           ct_data,
  output logic [ROW_W-1:0]                      ct_row,
  output logic                                  ct_last
);
  localparam int CW        = CIPHERTEXT_WIDTH;
  localparam int PW        = PLAINTEXT_WIDTH;
  localparam int DELTA     = CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS;
  localparam int ROW_BEATS = (BIG_N + LANES - 1) / LANES;
  localparam int BEAT_W    = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam int PAD_N     = ROW_BEATS * LANES;
  localparam logic [CW:0]      Q_EXT      = (CW+1)'(CIPHERTEXT_MODULUS);
  localparam logic [PW+CW-1:0] Q_WIDE     = (PW+CW)'(CIPHERTEXT_MODULUS);
  localparam logic [PW+CW-1:0] DELTA_WIDE = (PW+CW)'(DELTA);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ROW_BEATS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(DIMENSION);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t            state_q, state_d;
  logic [BIG_N-1:0]  sel_q, sel_d;
  logic [PAD_N-1:0]  sel_shift_q, sel_shift_d;
  logic [CW-1:0]     msg_q, msg_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CW-1:0]     ct_data_q, ct_data_d;
  logic              ct_last_q, ct_last_d;
  logic              busy_q, busy_d;
  logic              pk_ready_q, pk_ready_d;
  logic              ct_valid_q, ct_valid_d;

  logic [PW+CW-1:0]  msg_prod;
  logic [CW-1:0]     msg_term;
  logic [CW-1:0]     row_sum;
  logic [CW:0]       msg_raw;
  logic [CW-1:0]     row_final;

  // Lane k's mask bit sits at the bottom of the shifted mask; padding beyond BIG_N is zero.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [CW-1:0] acc_in;
    logic [CW-1:0] acc_out;
    logic [CW:0]   raw;
    if (gi == 0) begin : g_first
      assign acc_in = acc_q;
    end else begin : g_next
      assign acc_in = g_lane[gi-1].acc_out;
    end
    assign raw     = {1'b0, acc_in} + {1'b0, pk_data[gi*CW +: CW]};
    assign acc_out = !sel_shift_q[gi] ? acc_in
                   : (raw >= Q_EXT)   ? CW'(raw - Q_EXT)
                   :                    raw[CW-1:0];
  end

  assign row_sum   = g_lane[LANES-1].acc_out;
  assign msg_raw   = {1'b0, row_sum} + {1'b0, msg_q};
  assign row_final = (row_q != LAST_ROW) ? row_sum
                   : (msg_raw >= Q_EXT)  ? CW'(msg_raw - Q_EXT)
                   :                       msg_raw[CW-1:0];
  assign msg_prod  = {{CW{1'b0}}, plaintext} * DELTA_WIDE;
  assign msg_term  = CW'(msg_prod % Q_WIDE);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_shift_d = sel_shift_q;
    msg_d       = msg_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    row_d       = row_q;
    ct_data_d   = ct_data_q;
    ct_last_d   = ct_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d       = noise_select;
          sel_shift_d = PAD_N'(noise_select);
          msg_d       = msg_term;
          acc_d       = '0;
          beat_d      = '0;
          row_d       = '0;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        if (pk_valid) begin
          sel_shift_d = sel_shift_q >> LANES;
          if (beat_q == LAST_BEAT) begin
            ct_data_d = row_final;
            ct_last_d = (row_q == LAST_ROW);
            state_d   = EMIT;
          end else begin
            acc_d  = row_sum;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (ct_ready) begin
          if (ct_last_q) begin
            state_d = IDLE;
          end else begin
            row_d       = row_q + 1'b1;
            acc_d       = '0;
            beat_d      = '0;
            sel_shift_d = PAD_N'(sel_q);
            state_d     = ACCUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    pk_ready_d = (state_d == ACCUM);
    ct_valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      sel_shift_q <= '0;
      msg_q       <= '0;
      acc_q       <= '0;
      beat_q      <= '0;
      row_q       <= '0;
      ct_data_q   <= '0;
      ct_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      pk_ready_q  <= 1'b0;
      ct_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_shift_q <= sel_shift_d;
      msg_q       <= msg_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      row_q       <= row_d;
      ct_data_q   <= ct_data_d;
      ct_last_q   <= ct_last_d;
      busy_q      <= busy_d;
      pk_ready_q  <= pk_ready_d;
      ct_valid_q  <= ct_valid_d;
    end
  end

  assign busy     = busy_q;
  assign pk_ready = pk_ready_q;
  assign ct_valid = ct_valid_q;
  assign ct_data  = ct_data_q;
  assign ct_row   = row_q;
  assign ct_last  = ct_last_q;
endmodule

// File: tb/tb_encrypt_stream.sv
// Bench for encrypt_stream: two instances (N=4/LANES=1 and N=5/LANES=4) driven from a
// vector table, with a scoreboard queue checked on every ciphertext handshake.
module tb_encrypt_stream;
  localparam int CW = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      start_v;
  logic [5:0]      plaintext;
  logic [4:0]      noise_select;
  logic            pk_valid;
  logic            ct_ready;
  logic [4*CW-1:0] pk_bus;

  logic busy0, pk_ready0, ct_valid0, ct_last0;
  logic busy1, pk_ready1, ct_valid1, ct_last1;
  logic [CW-1:0] ct_data0, ct_data1;
  logic [0:0]    ct_row0, ct_row1;

  encrypt_stream #(.DIMENSION(1), .BIG_N(4), .LANES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .plaintext(plaintext),
    .noise_select(noise_select[3:0]), .busy(busy0), .pk_valid(pk_valid),
    .pk_ready(pk_ready0), .pk_data(pk_bus[CW-1:0]), .ct_valid(ct_valid0),
    .ct_ready(ct_ready), .ct_data(ct_data0), .ct_row(ct_row0), .ct_last(ct_last0)
  );

  encrypt_stream #(.DIMENSION(1), .BIG_N(5), .LANES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .plaintext(plaintext),
    .noise_select(noise_select), .busy(busy1), .pk_valid(pk_valid),
    .pk_ready(pk_ready1), .pk_data(pk_bus), .ct_valid(ct_valid1),
    .ct_ready(ct_ready), .ct_data(ct_data1), .ct_row(ct_row1), .ct_last(ct_last1)
  );

  typedef struct packed {
    logic                  dut;
    logic [5:0]            m;
    logic [4:0]            sel;
    logic [1:0][4:0][9:0]  pk;
    logic [CW-1:0]         exp0;
    logic [CW-1:0]         exp1;
  } vec_t;

  typedef struct packed {
    logic          dut;
    logic [CW-1:0] data;
    logic          row;
    logic          last;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, expv);
    end else begin
      passes++;
    end
  endtask

  function automatic logic busy_of(input logic d);
    return d ? busy1 : busy0;
  endfunction
  function automatic logic pk_ready_of(input logic d);
    return d ? pk_ready1 : pk_ready0;
  endfunction
  function automatic logic ct_valid_of(input logic d);
    return d ? ct_valid1 : ct_valid0;
  endfunction
  function automatic logic [CW-1:0] ct_data_of(input logic d);
    return d ? ct_data1 : ct_data0;
  endfunction
  function automatic logic ct_row_of(input logic d);
    return d ? ct_row1[0] : ct_row0[0];
  endfunction

  function automatic vec_t mk(input logic d, input int m, input int sel,
                              input int a0, input int a1, input int a2, input int a3, input int a4,
                              input int b0, input int b1, input int b2, input int b3, input int b4,
                              input int e0, input int e1);
    vec_t v;
    v.dut = d; v.m = 6'(m); v.sel = 5'(sel);
    v.pk[0][0] = 10'(a0); v.pk[0][1] = 10'(a1); v.pk[0][2] = 10'(a2);
    v.pk[0][3] = 10'(a3); v.pk[0][4] = 10'(a4);
    v.pk[1][0] = 10'(b0); v.pk[1][1] = 10'(b1); v.pk[1][2] = 10'(b2);
    v.pk[1][3] = 10'(b3); v.pk[1][4] = 10'(b4);
    v.exp0 = CW'(e0); v.exp1 = CW'(e1);
    return v;
  endfunction

  // Reference: plain integer sum of selected columns, message term on row 1, then mod q.
  function automatic logic [CW-1:0] model(input vec_t v, input int r);
    int s;
    int ncols;
    s = 0;
    ncols = v.dut ? 5 : 4;
    for (int c = 0; c < ncols; c++) if (v.sel[c]) s += int'(v.pk[r][c]);
    if (r == 1) s += int'(v.m) * 16;
    return CW'(s % 1024);
  endfunction

  task automatic sb_check(input logic d, input logic [CW-1:0] data, input logic row, input logic last);
    exp_t e;
    $display("ct dut%0d row=%0d data=%0d last=%0d", d, row, data, last);
    if (sb.size() == 0) begin
      checks++; fails++;
      $display("FAIL sb_unexpected_ct: got data %0d on dut%0d, required no output", data, d);
      return;
    end
    e = sb.pop_front();
    chk("ct_dut",  32'(d),    32'(e.dut));
    chk("ct_data", 32'(data), 32'(e.data));
    chk("ct_row",  32'(row),  32'(e.row));
    chk("ct_last", 32'(last), 32'(e.last));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ct_valid0 && ct_ready) sb_check(1'b0, ct_data0, ct_row0[0], ct_last0);
      if (ct_valid1 && ct_ready) sb_check(1'b1, ct_data1, ct_row1[0], ct_last1);
    end
  end

  task automatic run_vec(input vec_t v, input bit bubbles, input bit stall, input bit hold,
                         input bit glitch, output int busy_cycles);
    int rb, lanes, ncols, beat, row, held, cyc, col;
    bit glitched;
    exp_t e;
    lanes = v.dut ? 4 : 1;
    ncols = v.dut ? 5 : 4;
    rb    = v.dut ? 2 : 4;
    beat = 0; row = 0; held = 0; cyc = 0; glitched = 0; busy_cycles = 0;
    e.dut = v.dut; e.data = v.exp0; e.row = 1'b0; e.last = 1'b0;
    sb.push_back(e);
    e.data = v.exp1; e.row = 1'b1; e.last = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start_v = 2'b00;
    start_v[v.dut] = 1'b1;
    plaintext = v.m; noise_select = v.sel; pk_valid = 1'b0; ct_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      start_v = 2'b00;
      if (glitch && !glitched && row == 0 && beat == rb - 1) begin
        start_v[v.dut] = 1'b1;
        plaintext = ~v.m;
        noise_select = ~v.sel;
        glitched = 1'b1;
      end
      pk_bus = '0;
      for (int k = 0; k < lanes; k++) begin
        col = beat * lanes + k;
        pk_bus[k*CW +: CW] = (row < 2 && col < ncols) ? CW'(v.pk[row][col]) : CW'(1023);
      end
      pk_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      ct_ready = (hold && held < 5) ? 1'b0 : (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      @(negedge clk);
      if (!busy_of(v.dut)) break;
      busy_cycles++;
      if (hold && held < 5 && ct_valid_of(v.dut)) begin
        held++;
        chk("hold_ct_data",  32'(ct_data_of(v.dut)),  32'(v.exp0));
        chk("hold_ct_row",   32'(ct_row_of(v.dut)),   32'd0);
        chk("hold_pk_ready", 32'(pk_ready_of(v.dut)), 32'd0);
      end
      if (pk_valid && pk_ready_of(v.dut)) begin
        beat++;
        if (beat == rb) begin
          beat = 0;
          row++;
        end
      end
      cyc++;
      if (cyc > 500) begin
        chk("op_timeout_cycles", 32'(cyc), 32'd0);
        break;
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  function automatic logic [31:0] outs0();
    return 32'({busy0, pk_ready0, ct_valid0, ct_last0, ct_row0, ct_data0});
  endfunction
  function automatic logic [31:0] outs1();
    return 32'({busy1, pk_ready1, ct_valid1, ct_last1, ct_row1, ct_data1});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int bc;
    rst_n = 1'b0; start_v = 2'b00; plaintext = '0; noise_select = '0;
    pk_valid = 1'b0; ct_ready = 1'b0; pk_bus = '0;

    tbl[0] = mk(0, 5,  5'b00101, 100, 200, 300, 400, 0,    1000, 50, 30, 7, 0,    400, 86);
    tbl[1] = mk(1, 5,  5'b00101, 100, 200, 300, 400, 999,  1000, 50, 30, 7, 999,  400, 86);
    tbl[2] = mk(1, 5,  5'b11111, 1, 2, 3, 4, 5,            1, 2, 3, 4, 5,         15, 95);
    tbl[3] = mk(0, 63, 5'b00000, 100, 200, 300, 400, 0,    1000, 50, 30, 7, 0,    0, 1008);
    tbl[4] = mk(1, 63, 5'b00000, 100, 200, 300, 400, 500,  1000, 50, 30, 7, 9,    0, 1008);
    tbl[5] = mk(1, 10, 5'b11111, 1023, 1023, 1023, 1023, 1023, 1000, 900, 800, 700, 600, 1019, 64);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_dut0", outs0(), 32'd0);
    chk("reset_outs_dut1", outs1(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs_dut0", outs0(), 32'd0);
    chk("idle_outs_dut1", outs1(), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], 1'b0, 1'b0, 1'b0, 1'b0, bc);
      if (i == 0) chk("busy_cycles_lanes1", 32'(bc), 32'd10);
      if (i == 1) chk("busy_cycles_lanes4", 32'(bc), 32'd6);
    end

    run_vec(tbl[0], 1'b0, 1'b0, 1'b1, 1'b0, bc);
    chk("busy_cycles_backpressure", 32'(bc), 32'd15);

    run_vec(tbl[3], 1'b0, 1'b0, 1'b0, 1'b1, bc);
    run_vec(tbl[4], 1'b0, 1'b0, 1'b0, 1'b1, bc);
    run_vec(tbl[2], 1'b1, 1'b1, 1'b0, 1'b0, bc);
    run_vec(tbl[0], 1'b1, 1'b1, 1'b0, 1'b0, bc);

    for (int i = 0; i < 8; i++) begin
      v.dut = i[0];
      v.m   = 6'($urandom);
      v.sel = 5'($urandom);
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 5; c++)
          v.pk[r][c] = 10'($urandom_range(0, 1023));
      v.exp0 = model(v, 0);
      v.exp1 = model(v, 1);
      run_vec(v, 1'b1, 1'b1, 1'b0, 1'b0, bc);
    end

    // Abort mid-row: two beats accepted, then reset with no ct output expected.
    @(posedge clk); #1;
    start_v = 2'b01; plaintext = 6'd5; noise_select = 5'b00101;
    @(posedge clk); #1;
    start_v = 2'b00; pk_valid = 1'b1; ct_ready = 1'b1; pk_bus = '0; pk_bus[CW-1:0] = CW'(100);
    @(posedge clk); #1;
    pk_bus[CW-1:0] = CW'(200);
    @(posedge clk); #1;
    chk("mid_accum_busy", 32'(busy0), 32'd1);
    pk_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs_dut0", outs0(), 32'd0);
    chk("async_reset_outs_dut1", outs1(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec(tbl[0], 1'b0, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_cycles_after_abort", 32'(bc), 32'd10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
